// File: rtl/bias_add_bank.sv
// bias_add_bank: loadable per-group bias bank feeding a 2-stage saturating
// bias-add pipeline with valid/ready handshake on both sides.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   cfg_we/cfg_addr/cfg_data   bias group write (one group of N_CH biases)
//   in_valid/in_ready          input beat handshake
//   in_grp/in_data             bias group select and N_CH accumulator sums
//   out_valid/out_ready        output beat handshake
//   out_data/sat_flag          saturated results and per-channel clamp flags
//
// Option macro BIAS_ADD_RELU_EN: when defined, negative results are
// forced to 0 in S2. sat_flag still reports the pre-ReLU clamp.
module bias_add_bank #(
  parameter int N_CH  = 16,
  parameter int DW    = 18,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we,
  input  logic [AW-1:0]      cfg_addr,
  input  logic [N_CH*DW-1:0] cfg_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [AW-1:0]      in_grp,
  input  logic [N_CH*DW-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N_CH*DW-1:0] out_data,
  output logic [N_CH-1:0]    sat_flag
);

  localparam int W = N_CH * DW;

  // One extra bit so the range test stays meaningful
  // even when DEPTH is a power of two.
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  localparam logic [DW-1:0] MAX_V = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] MIN_V = {1'b1, {(DW-1){1'b0}}};

  logic [W-1:0]    bank_q [DEPTH];
  logic [W-1:0]    bank_d [DEPTH];

  logic            s1_v_q;
  logic            s1_v_d;
  logic [W-1:0]    s1_dat_q;
  logic [W-1:0]    s1_dat_d;
  logic [W-1:0]    s1_bias_q;
  logic [W-1:0]    s1_bias_d;

  logic            s2_v_q;
  logic            s2_v_d;
  logic [W-1:0]    s2_dat_q;
  logic [W-1:0]    s2_dat_d;
  logic [N_CH-1:0] s2_sat_q;
  logic [N_CH-1:0] s2_sat_d;

  logic            s1_adv;
  logic            s2_adv;
  logic            cfg_hit;
  logic            grp_hit;
  logic [W-1:0]    bias_rd;
  logic [W-1:0]    res;
  logic [N_CH-1:0] sat;

  // Handshake: a stage advances when it is empty
  // or the stage after it advances.
  assign s2_adv   = !s2_v_q || out_ready;
  assign s1_adv   = !s1_v_q || s2_adv;
  assign in_ready = s1_adv;

  assign cfg_hit = cfg_we && ({1'b0, cfg_addr} < DEPTH_W);
  assign grp_hit = {1'b0, in_grp} < DEPTH_W;

  // Read uses the current bank contents, so a same-cycle
  // write to the same group is seen only by later beats.
  assign bias_rd = grp_hit ? bank_q[in_grp] : '0;

  always_comb begin
    for (int g = 0; g < DEPTH; g++) begin
      bank_d[g] = bank_q[g];
    end
    if (cfg_hit) begin
      bank_d[cfg_addr] = cfg_data;
    end
  end

  always_comb begin
    s1_v_d    = s1_v_q;
    s1_dat_d  = s1_dat_q;
    s1_bias_d = s1_bias_q;
    if (s1_adv) begin
      s1_v_d = in_valid;
      if (in_valid) begin
        s1_dat_d  = in_data;
        s1_bias_d = bias_rd;
      end
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW:0]   sum;
    logic [DW-1:0] r;
    logic          s;

    assign a   = s1_dat_q[i*DW +: DW];
    assign b   = s1_bias_q[i*DW +: DW];
    assign sum = {a[DW-1], a} + {b[DW-1], b};

    // Overflow iff the two top bits of the
    // DW+1 bit sum disagree; sum[DW] is the true sign.
    always_comb begin
      r = sum[DW-1:0];
      s = 1'b0;
      if (sum[DW] != sum[DW-1]) begin
        s = 1'b1;
        r = sum[DW] ? MIN_V : MAX_V;
      end
`ifdef BIAS_ADD_RELU_EN
      if (r[DW-1]) begin
        r = '0;
      end
`endif
    end

    assign res[i*DW +: DW] = r;
    assign sat[i]          = s;
  end

  always_comb begin
    s2_v_d   = s2_v_q;
    s2_dat_d = s2_dat_q;
    s2_sat_d = s2_sat_q;
    if (s2_adv) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        s2_dat_d = res;
        s2_sat_d = sat;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int g = 0; g < DEPTH; g++) begin
        bank_q[g] <= '0;
      end
    end else begin
      for (int g = 0; g < DEPTH; g++) begin
        bank_q[g] <= bank_d[g];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q    <= 1'b0;
      s1_dat_q  <= '0;
      s1_bias_q <= '0;
      s2_v_q    <= 1'b0;
      s2_dat_q  <= '0;
      s2_sat_q  <= '0;
    end else begin
      s1_v_q    <= s1_v_d;
      s1_dat_q  <= s1_dat_d;
      s1_bias_q <= s1_bias_d;
      s2_v_q    <= s2_v_d;
      s2_dat_q  <= s2_dat_d;
      s2_sat_q  <= s2_sat_d;
    end
  end

  assign out_valid = s2_v_q;
  assign out_data  = s2_dat_q;
  assign sat_flag  = s2_sat_q;

endmodule

// File: tb/tb_bias_add_bank.sv
// tb_bias_add_bank: directed + random bench for bias_add_bank.
// Scoreboard queue of expected {sat_flag, out_data} per accepted beat.
module tb_bias_add_bank;

  localparam int N_CH  = 16;
  localparam int DW    = 18;
  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int W     = N_CH * DW;
  localparam int MAXV  = 131071;
  localparam int MINV  = -131072;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cfg_we;
  logic [AW-1:0]   cfg_addr;
  logic [W-1:0]    cfg_data;
  logic            in_valid;
  logic            in_ready;
  logic [AW-1:0]   in_grp;
  logic [W-1:0]    in_data;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_data;
  logic [N_CH-1:0] sat_flag;

  int total = 0;
  int bad   = 0;

  logic [W+N_CH-1:0] sbq[$];
  int mdl [DEPTH][N_CH];

  always #5 clk = ~clk;

  bias_add_bank dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_grp   (in_grp),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .sat_flag (sat_flag)
  );

  task automatic chk(string tag, logic [W+N_CH-1:0] obs,
                     logic [W+N_CH-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] pk2(int a, int b);
    logic [W-1:0] r;
    r = '0;
    r[DW-1:0]    = a[DW-1:0];
    r[2*DW-1:DW] = b[DW-1:0];
    return r;
  endfunction

  function automatic logic [W-1:0] fill(int v);
    logic [W-1:0] r;
    for (int i = 0; i < N_CH; i++) r[i*DW +: DW] = v[DW-1:0];
    return r;
  endfunction

  function automatic logic [W-1:0] rnd_vec();
    logic [W-1:0] r;
    int v;
    for (int i = 0; i < N_CH; i++) begin
      v = int'($urandom);
      r[i*DW +: DW] = v[DW-1:0];
    end
    return r;
  endfunction

  function automatic logic [W+N_CH-1:0] model(logic [W-1:0] din, int grp);
    logic [W-1:0]    d;
    logic [N_CH-1:0] s;
    int x, b, v;
    for (int i = 0; i < N_CH; i++) begin
      x = int'(signed'(din[i*DW +: DW]));
      b = (grp < DEPTH) ? mdl[grp][i] : 0;
      v = x + b;
      s[i] = 1'b0;
      if (v > MAXV) begin
        v = MAXV;
        s[i] = 1'b1;
      end else if (v < MINV) begin
        v = MINV;
        s[i] = 1'b1;
      end
`ifdef BIAS_ADD_RELU_EN
      if (v < 0) v = 0;
`endif
      d[i*DW +: DW] = v[DW-1:0];
    end
    return {s, d};
  endfunction

  // Push expectation before applying the write: read-before-write.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        total++;
        assert (sbq.size() > 0) else begin
          bad++;
          $error("FAIL sb_extra observed=%h expected=none",
                 {sat_flag, out_data});
        end
        if (sbq.size() > 0)
          chk("sb_data", {sat_flag, out_data}, sbq.pop_front());
      end
      if (in_valid && in_ready)
        sbq.push_back(model(in_data, int'(in_grp)));
      if (cfg_we && int'(cfg_addr) < DEPTH)
        for (int i = 0; i < N_CH; i++)
          mdl[cfg_addr][i] = int'(signed'(cfg_data[i*DW +: DW]));
    end
  end

  task automatic cfg_write(int g, logic [W-1:0] d);
    cfg_we   = 1'b1;
    cfg_addr = g[AW-1:0];
    cfg_data = d;
    @(posedge clk); #1;
    cfg_we   = 1'b0;
  endtask

  task automatic drain(string tag);
    int n;
    n = 0;
    while ((sbq.size() != 0 || out_valid) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, sbq.size(), 0);
  endtask

  int k, acc, n;
  logic a;

  initial begin
    foreach (mdl[g, i]) mdl[g][i] = 0;
    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    in_valid = 1'b0; in_grp = '0; in_data = '0; out_ready = 1'b1;
    #12 rst_n = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_data", out_data, 0);
    chk("rst_sat_flag", sat_flag, 0);
    @(posedge clk); #1;

    // basic add + latency
    cfg_write(3, pk2(5972, -100));
    in_valid = 1'b1; in_grp = 3; in_data = pk2(100, 50);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("t1_lat1", out_valid, 0);
    @(posedge clk); #1;
    chk("t1_lat2", out_valid, 1);
    chk("t1_data", out_data, pk2(6072, -50));
    chk("t1_sat", sat_flag, 0);
    drain("t1_drain");

    // saturation both directions
    cfg_write(4, pk2(131000, -131000));
    in_valid = 1'b1; in_grp = 4; in_data = pk2(1000, -1000);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("t2_data", out_data, pk2(131071, -131072));
    chk("t2_sat", sat_flag, 3);
    drain("t2_drain");

    // backpressure
    out_ready = 1'b0; in_grp = 3; k = 0; acc = 0;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1; in_data = pk2(k + 1, 10 * k);
      #1; a = in_ready;
      @(posedge clk); #1;
      if (a) begin acc++; k++; end
    end
    chk("t3_accepted", acc, 2);
    chk("t3_stall", in_ready, 0);
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      in_valid = (k < 4);
      if (k < 4) in_data = pk2(k + 1, 10 * k);
      #1;
      chk("t3_nogap", out_valid, 1);
      a = in_valid && in_ready;
      @(posedge clk); #1;
      if (a) k++;
    end
    in_valid = 1'b0;
    chk("t3_all_in", k, 4);
    drain("t3_drain");

    // write/read collision
    cfg_write(5, pk2(10, 0));
    cfg_we = 1'b1; cfg_addr = 5; cfg_data = pk2(20, 0);
    in_valid = 1'b1; in_grp = 5; in_data = pk2(1, 0);
    @(posedge clk); #1;
    cfg_we = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("t4_old", out_data, pk2(11, 0));
    @(posedge clk); #1;
    chk("t4_new", out_data, pk2(21, 0));
    drain("t4_drain");

    // reset mid-stream
    in_valid = 1'b1; in_grp = 3; in_data = pk2(1, 1);
    @(posedge clk); #1;
    in_data = pk2(2, 2);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("t5_inflight", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async", out_valid, 0);
    sbq.delete();
    foreach (mdl[g, i]) mdl[g][i] = 0;
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t5_ready", in_ready, 1);
    in_valid = 1'b1; in_grp = 3; in_data = fill(7);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("t5_cleared", {sat_flag, out_data}, {16'h0, fill(7)});
    drain("t5_drain");

    // negative result (ReLU option)
    cfg_write(7, pk2(-50, 0));
    in_valid = 1'b1; in_grp = 7; in_data = pk2(10, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
`ifdef BIAS_ADD_RELU_EN
    chk("t6_relu", out_data, pk2(0, 0));
`else
    chk("t6_neg", out_data, pk2(-40, 0));
`endif
    chk("t6_sat", sat_flag, 0);
    drain("t6_drain");

    // random traffic with random backpressure
    cfg_write(9, rnd_vec());
    cfg_write(10, rnd_vec());
    for (int j = 0; j < 40; j++) begin
      in_valid  = ($urandom_range(3) != 0);
      in_grp    = ($urandom_range(1) != 0) ? 6'd9 : 6'd10;
      in_data   = rnd_vec();
      out_ready = ($urandom_range(2) != 0);
      cfg_we    = (j == 20);
      cfg_addr  = 9;
      cfg_data  = rnd_vec();
      @(posedge clk); #1;
    end
    cfg_we = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drain("rnd_drain");

    n = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
